// File: rtl/cpa_resolve_stage_pkg.sv
// Shared width parameters for the carry-save adder tree and its resolve stage.
package cpa_resolve_stage_pkg;

    // Operand width and number of carry-generating elements feeding the tree.
    localparam int BITS      = 32;
    localparam int CGES      = 13;

    // Carry-save vectors grow by clog2(CGES) guard bits over the operand width.
    localparam int MAX_W     = BITS + $clog2(CGES);

    // Default split point: the low segment covers the lower half of the vector.
    localparam int SPLIT_DEF = MAX_W / 2;

    // Default width of the completed-transfer counter.
    localparam int CNT_W_DEF = 16;

    // Returns 1 when a split point leaves both adder segments non-empty.
    function automatic logic split_is_legal(input int max_w, input int split);
        logic ok;
        if ((split >= 1) && (split <= (max_w - 1))) begin
            ok = 1'b1;
        end else begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/cpa_resolve_stage_segment.sv
// Building blocks of the resolve stage: a ripple segment adder with carry
// in/out, and the enable-register cell used for every pipeline register.

module cpa_segment #(
    parameter int W = 18
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] total_s;

    // Widen by one bit so the carry-out falls out of the same addition.
    always_comb begin
        total_s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    end

    assign s    = total_s[W-1:0];
    assign cout = total_s[W];

endmodule

module cpa_en_reg #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Load on enable, otherwise hold; cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_r <= {W{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/cpa_resolve_stage.sv
// Two-stage carry-propagate resolve of a carry-save pair with a single
// global advance, valid/ready handshake and a saturating transfer counter.
module cpa_resolve_stage
    import cpa_resolve_stage_pkg::*;
#(
    parameter int MAX   = MAX_W,
    parameter int SPLIT = SPLIT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic [MAX-1:0]   vs,
    input  logic [MAX-1:0]   vc,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [MAX-1:0]   sum,
    output logic             sign,
    output logic             zero,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam int HI_W  = MAX - SPLIT;
    localparam int S1_W  = 1 + SPLIT + 2 * HI_W;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Saturating increment: the counter parks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Handshake and load enables.
    logic             adv_s;
    logic             ld1_s;
    logic             ld2_s;
    logic             xfer_s;

    // Stage 1 datapath.
    logic [SPLIT-1:0] lo_s;
    logic             c1_s;
    logic [S1_W-1:0]  s1_d_s;
    logic [S1_W-1:0]  s1_q_s;
    logic             v1_r;
    logic             c1_r;
    logic [SPLIT-1:0] lo1_r;
    logic [HI_W-1:0]  vs_hi_r;
    logic [HI_W-1:0]  vc_hi_r;

    // Stage 2 datapath.
    logic [HI_W-1:0]  hi_s;
    logic             hi_cout_unused_s;
    logic             v2_r;
    logic [MAX-1:0]   s2_r;

    logic [CNT_W-1:0] cnt_r;

    // One advance for the whole pipe: move whenever the output slot is free or draining.
    always_comb begin
        adv_s  = ~v2_r | out_ready;
        ld1_s  = adv_s & in_valid;
        ld2_s  = adv_s & v1_r;
        xfer_s = v2_r & out_ready;
    end

    // Low segment resolves straight from the inputs; its carry feeds stage 2.
    cpa_segment #(.W(SPLIT)) u_lo_seg (
        .a    (vs[SPLIT-1:0]),
        .b    (vc[SPLIT-1:0]),
        .cin  (1'b0),
        .s    (lo_s),
        .cout (c1_s)
    );

    assign s1_d_s = {c1_s, lo_s, vs[MAX-1:SPLIT], vc[MAX-1:SPLIT]};

    cpa_en_reg #(.W(1)) u_v1_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv_s),
        .d       (in_valid),
        .q       (v1_r)
    );

    // Data only loads alongside a real input so idle cycles do not toggle it.
    cpa_en_reg #(.W(S1_W)) u_s1_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ld1_s),
        .d       (s1_d_s),
        .q       (s1_q_s)
    );

    assign {c1_r, lo1_r, vs_hi_r, vc_hi_r} = s1_q_s;

    // High segment completes the add; the carry out of the top bit is mod 2^MAX.
    cpa_segment #(.W(HI_W)) u_hi_seg (
        .a    (vs_hi_r),
        .b    (vc_hi_r),
        .cin  (c1_r),
        .s    (hi_s),
        .cout (hi_cout_unused_s)
    );

    cpa_en_reg #(.W(1)) u_v2_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (adv_s),
        .d       (v1_r),
        .q       (v2_r)
    );

    cpa_en_reg #(.W(MAX)) u_s2_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (ld2_s),
        .d       ({hi_s, lo1_r}),
        .q       (s2_r)
    );

    // Count completed transfers; clear wins over a same-cycle transfer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (xfer_s) begin
            cnt_r <= sat_inc(cnt_r);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign in_ready  = adv_s;
    assign out_valid = v2_r;
    assign sum       = s2_r;
    assign sign      = s2_r[MAX-1];
    assign zero      = (s2_r == {MAX{1'b0}});
    assign xfer_cnt  = cnt_r;

endmodule

// File: tb/tb_cpa_resolve_stage.sv
// Self-checking bench for cpa_resolve_stage: a queue-based reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_cpa_resolve_stage;

    localparam int MAX   = 36;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset_n;
    logic             clr;
    logic             in_valid;
    logic [MAX-1:0]   vs;
    logic [MAX-1:0]   vc;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [MAX-1:0]   sum;
    logic             sign;
    logic             zero;
    logic [CNT_W-1:0] xfer_cnt;

    int n_vec = 0;
    int n_err = 0;

    cpa_resolve_stage #(.MAX(36), .SPLIT(18), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .vs        (vs),
        .vc        (vc),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .sign      (sign),
        .zero      (zero),
        .xfer_cnt  (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepted results in order, plus occupancy of the two slots.
    logic [MAX-1:0]   exp_q[$];
    logic             m_v1;
    logic             m_v2;
    logic [CNT_W-1:0] m_cnt;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_v1  <= 1'b0;
            m_v2  <= 1'b0;
            m_cnt <= '0;
            exp_q.delete();
        end else begin
            if (clr)
                m_cnt <= '0;
            else if (m_v2 && out_ready && m_cnt != 16'hFFFF)
                m_cnt <= m_cnt + 16'd1;
            if (m_v2 && out_ready && exp_q.size() > 0)
                void'(exp_q.pop_front());
            if (!m_v2 || out_ready) begin
                m_v2 <= m_v1;
                m_v1 <= in_valid;
                if (in_valid)
                    exp_q.push_back(vs + vc);
            end
        end
    end

    // Compare process: every cycle, away from the rising edge.
    always @(negedge clk) begin
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_v2});
        chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_v2 || out_ready)});
        chk("xfer_cnt", {48'd0, xfer_cnt}, {48'd0, m_cnt});
        if (m_v2) begin
            if (exp_q.size() == 0) begin
                chk("result_present", 64'd0, 64'd1);
            end else begin
                chk("sum", {28'd0, sum}, {28'd0, exp_q[0]});
                chk("sign", {63'd0, sign}, {63'd0, exp_q[0][MAX-1]});
                chk("zero", {63'd0, zero}, {63'd0, (exp_q[0] == 36'd0)});
            end
        end
    end

    // Present one pair and hold it until the DUT accepts it (bounded).
    task automatic push(input logic [MAX-1:0] a, input logic [MAX-1:0] b);
        logic ok;
        int   waited;
        in_valid = 1'b1;
        vs       = a;
        vc       = b;
        waited   = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            waited++;
            if (waited > 200) begin
                chk("accept_timeout", 64'd0, 64'd1);
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    // Single input into an empty pipe with out_ready=1; literal result after two edges.
    task automatic one_shot(input string nm, input logic [MAX-1:0] a, input logic [MAX-1:0] b,
                            input logic [MAX-1:0] e_sum, input logic e_sign, input logic e_zero);
        in_valid = 1'b1;
        vs       = a;
        vc       = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
        chk({nm, "_sum"}, {28'd0, sum}, {28'd0, e_sum});
        chk({nm, "_sign"}, {63'd0, sign}, {63'd0, e_sign});
        chk({nm, "_zero"}, {63'd0, zero}, {63'd0, e_zero});
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n   = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        vs        = '0;
        vc        = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_sum", {28'd0, sum}, 64'd0);
        chk("rst_zero", {63'd0, zero}, 64'd1);
        chk("rst_sign", {63'd0, sign}, 64'd0);
        chk("rst_cnt", {48'd0, xfer_cnt}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic add, carry across the split, negative and zero results.
        one_shot("add5_7", 36'd5, 36'd7, 36'd12, 1'b0, 1'b0);
        chk("cnt_after_first", {48'd0, xfer_cnt}, 64'd1);
        one_shot("split_carry", 36'h3FFFF, 36'h00001, 36'h40000, 1'b0, 1'b0);
        one_shot("neg", 36'hFFFFFFFFF, 36'hFFFFFFFFE, 36'hFFFFFFFFD, 1'b1, 1'b0);
        one_shot("zero", 36'd1, 36'hFFFFFFFFF, 36'd0, 1'b0, 1'b1);
        chk("cnt_after_four", {48'd0, xfer_cnt}, 64'd4);

        // Backpressure: three inputs while the output is stalled.
        out_ready = 1'b0;
        push(36'd1, 36'd0);
        push(36'd2, 36'd0);
        chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
        chk("stall_valid", {63'd0, out_valid}, 64'd1);
        chk("stall_sum", {28'd0, sum}, 64'd1);
        @(posedge clk);
        #1;
        chk("stall_hold_sum", {28'd0, sum}, 64'd1);
        chk("stall_hold_ready", {63'd0, in_ready}, 64'd0);
        fork
            push(36'd3, 36'd0);
            begin
                repeat (2) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        chk("cnt_after_stall", {48'd0, xfer_cnt}, 64'd7);

        // Reset with two results in flight.
        out_ready = 1'b0;
        push(36'd10, 36'd0);
        push(36'd20, 36'd0);
        reset_n = 1'b0;
        #1;
        chk("midrst_valid", {63'd0, out_valid}, 64'd0);
        chk("midrst_cnt", {48'd0, xfer_cnt}, 64'd0);
        @(posedge clk);
        #1;
        reset_n   = 1'b1;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("after_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("after_rst_cnt", {48'd0, xfer_cnt}, 64'd0);

        // Stream to just below saturation, one transfer per cycle.
        in_valid = 1'b1;
        for (int k = 0; k < 65532; k++) begin
            vs = 36'(k) * 36'd37;
            vc = ~36'(k);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("near_sat", {48'd0, xfer_cnt}, 64'hFFFC);
        one_shot("sat1", 36'd1, 36'd2, 36'd3, 1'b0, 1'b0);
        one_shot("sat2", 36'd4, 36'd5, 36'd9, 1'b0, 1'b0);
        one_shot("sat3", 36'd6, 36'd7, 36'd13, 1'b0, 1'b0);
        chk("sat_reached", {48'd0, xfer_cnt}, 64'hFFFF);
        one_shot("sat4", 36'd8, 36'd9, 36'd17, 1'b0, 1'b0);
        chk("sat_hold", {48'd0, xfer_cnt}, 64'hFFFF);

        // Clear together with a transfer: clear wins.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        vs        = 36'd4;
        vc        = 36'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("clr_pre_valid", {63'd0, out_valid}, 64'd1);
        chk("clr_pre_sum", {28'd0, sum}, 64'd8);
        clr       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("clr_cnt", {48'd0, xfer_cnt}, 64'd0);
        chk("clr_drained", {63'd0, out_valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
